// File: rtl/mult_sched.sv
// mult_sched: round-robin scheduler that shares one sequential shift-add
// multiplier between two requesters and returns each product over a
// valid/ready response channel.
// Optional feature: define MULT_SCHED_ZERO_BYPASS_EN to answer requests with a
// zero operand directly (IDLE -> DONE, result 0) without running the multiplier.
module mult_sched #(
  parameter int DATA_WIDTH   = 32,
  parameter int MULT_LATENCY = DATA_WIDTH + 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req0_valid,
  output logic                      req0_ready,
  input  logic [DATA_WIDTH-1:0]     req0_a,
  input  logic [DATA_WIDTH-1:0]     req0_b,
  input  logic                      req1_valid,
  output logic                      req1_ready,
  input  logic [DATA_WIDTH-1:0]     req1_a,
  input  logic [DATA_WIDTH-1:0]     req1_b,
  output logic                      resp_valid,
  input  logic                      resp_ready,
  output logic                      resp_id,
  output logic [2*DATA_WIDTH-1:0]   resp_result,
  output logic                      busy,
  output logic                      mult_enable,
  output logic [DATA_WIDTH-1:0]     mult_a,
  output logic [DATA_WIDTH-1:0]     mult_b,
  input  logic [2*DATA_WIDTH-1:0]   mult_result
);

  localparam int CNT_W = $clog2(MULT_LATENCY + 1);
  // Counter value seen during the final RUN cycle (first RUN cycle sees 0).
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MULT_LATENCY - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t                    r_state;
  logic                      r_last_id;
  logic [CNT_W-1:0]          r_cnt;
  logic                      r_resp_valid;
  logic                      r_resp_id;
  logic [2*DATA_WIDTH-1:0]   r_resp_result;
  logic                      r_mult_enable;
  logic [DATA_WIDTH-1:0]     r_mult_a;
  logic [DATA_WIDTH-1:0]     r_mult_b;

  logic                      w_grant_id;
  logic                      w_accept;
  logic [DATA_WIDTH-1:0]     w_sel_a;
  logic [DATA_WIDTH-1:0]     w_sel_b;

  // Round-robin grant: a lone requester wins; on a tie the one not served last wins.
  always_comb begin
    w_grant_id = 1'b0;
    if (req0_valid && req1_valid) begin
      w_grant_id = ~r_last_id;
    end else begin
      w_grant_id = req1_valid;
    end
  end

  assign w_accept   = (r_state == ST_IDLE) && !rst && (req0_valid || req1_valid);
  assign req0_ready = w_accept && !w_grant_id;
  assign req1_ready = w_accept &&  w_grant_id;
  assign w_sel_a    = w_grant_id ? req1_a : req0_a;
  assign w_sel_b    = w_grant_id ? req1_b : req0_b;

  assign resp_valid  = r_resp_valid;
  assign resp_id     = r_resp_id;
  assign resp_result = r_resp_result;
  assign busy        = (r_state != ST_IDLE);
  assign mult_enable = r_mult_enable;
  assign mult_a      = r_mult_a;
  assign mult_b      = r_mult_b;

  // Scheduler FSM: accept, clear the multiplier, run it for the fixed latency, hold the product.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_last_id     <= 1'b1;
      r_cnt         <= '0;
      r_resp_valid  <= 1'b0;
      r_resp_id     <= 1'b0;
      r_resp_result <= '0;
      r_mult_enable <= 1'b0;
      r_mult_a      <= '0;
      r_mult_b      <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_mult_a  <= w_sel_a;
            r_mult_b  <= w_sel_b;
            r_resp_id <= w_grant_id;
            r_last_id <= w_grant_id;
`ifdef MULT_SCHED_ZERO_BYPASS_EN
            if ((w_sel_a == '0) || (w_sel_b == '0)) begin
              // A zero operand makes the product known; skip the multiplier entirely.
              r_resp_result <= '0;
              r_resp_valid  <= 1'b1;
              r_state       <= ST_DONE;
            end else begin
              r_state <= ST_LOAD;
            end
`else
            r_state <= ST_LOAD;
`endif
          end
        end
        ST_LOAD: begin
          // mult_enable is low here, which clears/loads the multiplier.
          r_cnt         <= '0;
          r_mult_enable <= 1'b1;
          r_state       <= ST_RUN;
        end
        ST_RUN: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST_CNT) begin
            r_resp_result <= mult_result;
            r_resp_valid  <= 1'b1;
            r_mult_enable <= 1'b0;
            r_state       <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (resp_ready) begin
            r_resp_valid <= 1'b0;
            r_state      <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_sched.sv
// tb_mult_sched: table-driven, hand-sequenced and randomized checks of
// mult_sched against a behavioural multiplier and a round-robin reference model.
module tb_mult_sched;
  localparam int DW  = 32;
  localparam int LAT = DW + 1;

  logic           clk = 1'b0;
  logic           rst;
  logic           req0_valid, req1_valid;
  logic           req0_ready, req1_ready;
  logic [DW-1:0]  req0_a, req0_b, req1_a, req1_b;
  logic           resp_valid, resp_ready, resp_id;
  logic [2*DW-1:0] resp_result;
  logic           busy, mult_enable;
  logic [DW-1:0]  mult_a, mult_b;
  logic [2*DW-1:0] mult_result;

  int n_asserts = 0;
  int n_fail    = 0;
  bit m_last    = 1'b1;   // reference round-robin pointer

  always #5 clk = ~clk;

  mult_sched #(.DATA_WIDTH(DW), .MULT_LATENCY(LAT)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_result(resp_result), .busy(busy), .mult_enable(mult_enable),
    .mult_a(mult_a), .mult_b(mult_b), .mult_result(mult_result)
  );

  // Behavioural multiplier: cleared while enable=0; the product is presented
  // during the LAT-th consecutive enable-high cycle, junk before that.
  int en_cnt = 0;
  always @(posedge clk) begin
    if (!mult_enable) en_cnt <= 0;
    else              en_cnt <= en_cnt + 1;
  end
  assign mult_result = (mult_enable && en_cnt >= LAT - 1) ? (64'(mult_a) * 64'(mult_b))
                                                          : (64'hA5A5_5A5A_0000_0000 | 64'(en_cnt));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    n_asserts++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp_v);
    end
  endtask

  // One full transaction from IDLE: present requests, wait for the response,
  // optionally stall the consumer, then take the product.
  task automatic run_txn(input bit v0, input logic [31:0] a0, input logic [31:0] b0,
                         input bit v1, input logic [31:0] a1, input logic [31:0] b1,
                         input int hold, input bit exp_id, input logic [63:0] exp_res);
    logic [31:0] ea, eb;
    int exp_lat, k, n_en;
    bit seen;
    ea = exp_id ? a1 : a0;
    eb = exp_id ? b1 : b0;
    exp_lat = LAT + 2;
`ifdef MULT_SCHED_ZERO_BYPASS_EN
    if (ea == 0 || eb == 0) exp_lat = 1;
`endif
    req0_valid = v0; req0_a = a0; req0_b = b0;
    req1_valid = v1; req1_a = a1; req1_b = b1;
    resp_ready = 1'b0;
    #1;
    chk("ready0_idle", 64'(req0_ready), 64'(!exp_id));
    chk("ready1_idle", 64'(req1_ready), 64'(exp_id));
    chk("busy_idle", 64'(busy), 64'd0);
    @(posedge clk);
    k = 0; n_en = 0; seen = 1'b0;
    while (!seen && k < 200) begin
      @(negedge clk);
      k++;
      if (resp_valid) begin
        seen = 1'b1;
      end else begin
        if (mult_enable) n_en++;
        if (k == 1) chk("enable_low_in_load", 64'(mult_enable), 64'd0);
        chk("readies_while_busy", 64'({req0_ready, req1_ready}), 64'd0);
        chk("busy_active", 64'(busy), 64'd1);
        chk("mult_ops_held", {mult_a, mult_b}, {ea, eb});
      end
    end
    chk("resp_latency", 64'(k), 64'(exp_lat));
    chk("enable_cycles", 64'(n_en), 64'((exp_lat == 1) ? 0 : LAT));
    chk("resp_result", resp_result, exp_res);
    chk("resp_id", 64'(resp_id), 64'(exp_id));
    for (int i = 1; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", 64'(resp_valid), 64'd1);
      chk("hold_result", resp_result, exp_res);
      chk("hold_id", 64'(resp_id), 64'(exp_id));
      chk("hold_readies", 64'({req0_ready, req1_ready}), 64'd0);
      chk("hold_enable", 64'(mult_enable), 64'd0);
      chk("hold_ops", {mult_a, mult_b}, {ea, eb});
    end
    resp_ready = 1'b1;
    #1;
    chk("no_accept_in_done", 64'({req0_ready, req1_ready}), 64'd0);
    @(negedge clk);
    chk("resp_taken", 64'(resp_valid), 64'd0);
    chk("idle_after_take", 64'(busy), 64'd0);
    resp_ready = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    m_last = exp_id;
    $display("txn id=%0d a=%h b=%h result=%h latency=%0d hold=%0d", exp_id, ea, eb, exp_res, k, hold);
  endtask

  typedef struct {
    bit          v0;
    logic [31:0] a0, b0;
    bit          v1;
    logic [31:0] a1, b1;
    int          hold;
    bit          exp_id;
    logic [63:0] exp_res;
  } vec_t;

  vec_t vecs[9];

  initial begin
    bit          anyresp;
    bit          v0, v1, eid;
    logic [31:0] a0, b0, a1, b1;
    int          sel;

    // Expected ids follow round-robin from a pointer that resets to 1.
    vecs[0] = '{1'b1, 32'd3, 32'd5, 1'b0, 32'd0, 32'd0, 0, 1'b0, 64'd15};
    vecs[1] = '{1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'd0, 32'd0, 0, 1'b0, 64'hFFFFFFFE00000001};
    vecs[2] = '{1'b1, 32'd2, 32'd3, 1'b1, 32'd4, 32'd5, 0, 1'b1, 64'd20};
    vecs[3] = '{1'b1, 32'd6, 32'd7, 1'b1, 32'd8, 32'd9, 0, 1'b0, 64'd42};
    vecs[4] = '{1'b1, 32'd6, 32'd7, 1'b1, 32'd8, 32'd9, 0, 1'b1, 64'd72};
    vecs[5] = '{1'b1, 32'd10, 32'd11, 1'b1, 32'd12, 32'd13, 10, 1'b0, 64'd110};
    vecs[6] = '{1'b0, 32'd0, 32'd0, 1'b1, 32'd0, 32'hFFFFFFFF, 0, 1'b1, 64'd0};
    vecs[7] = '{1'b1, 32'hFFFFFFFF, 32'd0, 1'b0, 32'd0, 32'd0, 2, 1'b0, 64'd0};
    vecs[8] = '{1'b1, 32'd100, 32'd200, 1'b1, 32'd300, 32'd400, 0, 1'b1, 64'd120000};

    rst = 1'b1; resp_ready = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
    repeat (3) @(negedge clk);
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    chk("reset_readies", 64'({req0_ready, req1_ready}), 64'd0);
    chk("reset_outputs", 64'({resp_valid, resp_id, busy, mult_enable}), 64'd0);
    chk("reset_result", resp_result, 64'd0);
    chk("reset_ops", {mult_a, mult_b}, 64'd0);
    rst = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);

    foreach (vecs[i])
      run_txn(vecs[i].v0, vecs[i].a0, vecs[i].b0, vecs[i].v1, vecs[i].a1, vecs[i].b1,
              vecs[i].hold, vecs[i].exp_id, vecs[i].exp_res);

    // Abort an operation mid-RUN with reset.
    req0_valid = 1'b1; req0_a = 32'd11; req0_b = 32'd13;
    @(posedge clk);
    repeat (10) @(negedge clk);
    chk("running_before_reset", 64'(mult_enable), 64'd1);
    rst = 1'b1; req1_valid = 1'b1;
    #1;
    chk("readies_in_reset", 64'({req0_ready, req1_ready}), 64'd0);
    @(negedge clk);
    chk("abort_outputs", 64'({resp_valid, resp_id, busy, mult_enable}), 64'd0);
    chk("abort_result", resp_result, 64'd0);
    chk("abort_ops", {mult_a, mult_b}, 64'd0);
    rst = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
    m_last = 1'b1;
    anyresp = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (resp_valid) anyresp = 1'b1;
    end
    chk("no_resp_after_abort", 64'(anyresp), 64'd0);
    run_txn(1'b1, 32'd21, 32'd2, 1'b1, 32'd5, 32'd5, 0, 1'b0, 64'd42);
    run_txn(1'b0, 32'd0, 32'd0, 1'b1, 32'd7, 32'd9, 0, 1'b1, 64'd63);

    // Randomized traffic against the reference model.
    for (int t = 0; t < 16; t++) begin
      sel = int'($urandom_range(1, 3));
      v0 = (sel != 2);
      v1 = (sel != 1);
      a0 = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      b0 = $urandom;
      a1 = $urandom;
      b1 = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      eid = (v0 && v1) ? !m_last : v1;
      run_txn(v0, a0, b0, v1, a1, b1, int'($urandom_range(0, 3)), eid,
              eid ? (64'(a1) * 64'(b1)) : (64'(a0) * 64'(b0)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/mult_sched.md
# mult_sched

Two-requester scheduler that shares one sequential shift-add multiplier (`rca_mult`-style: `clk`, `enable`, operands, 2*DATA_WIDTH result) between two clients. It arbitrates round-robin, loads operands, sequences the multiplier's enable, counts its fixed latency, captures the product and returns it over a valid/ready response channel. It sits between the client datapaths and the single multiplier instance.

## Interface
- DATA_WIDTH, 32: operand width; product is 2*DATA_WIDTH.
- MULT_LATENCY, DATA_WIDTH+1: cycles of `mult_enable`=1 after which `mult_result` is valid.
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- req0_valid / req1_valid  in  1  client request valid.
- req0_ready / req1_ready  out  1  request accepted this cycle when valid&ready.
- req0_a, req0_b / req1_a, req1_b  in  DATA_WIDTH  operands.
- resp_valid  out  1  product available.
- resp_ready  in  1  consumer takes product.
- resp_id  out  1  requester the product belongs to.
- resp_result  out  2*DATA_WIDTH  product.
- busy  out  1  high in any state except IDLE.
- mult_enable  out  1  multiplier enable; 0 = clear/load, 1 = run.
- mult_a, mult_b  out  DATA_WIDTH  multiplier operands, registered.
- mult_result  in  2*DATA_WIDTH  multiplier output.

## Operation
- States: IDLE, LOAD, RUN, DONE.
- IDLE: grant computed combinationally from valids; readies asserted only here, only for the granted requester. On accept: latch operands into `mult_a/mult_b`, latch id, go LOAD.
- Arbitration: one valid -> it wins. Both valid -> requester not served last wins. Last-served pointer resets to 1 (req0 wins first tie).
- LOAD: `mult_enable`=0 for exactly one cycle, counter cleared -> RUN.
- RUN: `mult_enable`=1, counter increments each cycle; in the MULT_LATENCY-th RUN cycle, `mult_result` is captured into `resp_result` -> DONE.
- DONE: `resp_valid`=1, `mult_enable`=0; `resp_result`, `resp_id` stable until `resp_ready`. On `resp_valid&resp_ready` -> IDLE; no accept in the same cycle.
- `mult_a/mult_b` held constant from LOAD through DONE.
- Reset values: `req*_ready`=0, `resp_valid`=0, `resp_result`=0, `resp_id`=0, `busy`=0, `mult_enable`=0, `mult_a`=0, `mult_b`=0; state IDLE.
- `rst` at any point, including mid-RUN, aborts the operation; the in-flight product is discarded and no response is issued.

## Timing
- Accept at edge ending cycle T; LOAD = T+1; RUN = T+2 .. T+1+MULT_LATENCY; `resp_valid` rises in T+2+MULT_LATENCY.
- Accept-to-`resp_valid` = MULT_LATENCY+2 cycles (35 at defaults).
- Minimum issue interval = MULT_LATENCY+3 cycles (response taken in first DONE cycle).
- Readies are 0 while `rst`=1 and in LOAD/RUN/DONE.
- Counter width is clog2(MULT_LATENCY+1); no wrap occurs.

## Configuration
- `MULT_SCHED_ZERO_BYPASS_EN` defined: on accept with either operand == 0, go IDLE -> DONE directly, `resp_result`=0, `resp_valid` in T+1; `mult_enable` stays 0, LOAD/RUN skipped.
- Not defined: every request takes the full multiplier path and latency, including zero operands.

## Test plan
- req0 a=3, b=5, resp_ready=1 -> `mult_enable` 0 for 1 cycle then 1 for 33 cycles; `resp_valid` at accept+35, `resp_result`=15, `resp_id`=0.
- Both requesters valid continuously with distinct operands -> grants alternate 0,1,0,1; every result equals a*b for its id.
- resp_ready held 0 for 10 cycles in DONE -> `resp_valid`, `resp_result`, `resp_id` stable; both readies 0; then resp_ready=1 -> IDLE next cycle.
- `rst` pulsed during RUN -> next cycle all outputs at reset values; following req1 a=7, b=9 -> `resp_result`=63, `resp_id`=1.
- a=0, b=0xFFFFFFFF -> with macro: `resp_valid` at accept+1, result 0, `mult_enable` never 1; without: `resp_valid` at accept+35, result 0.
- a=b=0xFFFFFFFF -> `resp_result`=0xFFFFFFFE00000001.
